// File: rtl/sram_test_controller_pkg.sv
// rtl/sram_test_controller_pkg.sv - shared state encoding and constants for the SRAM march test controller
package sram_test_controller_pkg;

  localparam int PATTERN_COUNT = 7;
  localparam int PIDX_W        = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GRST,
    ST_SETTLE,
    ST_WRITE,
    ST_READ,
    ST_RWAIT,
    ST_CHECK,
    ST_NEXT,
    ST_PASS,
    ST_FAIL
  } state_e;

  // A run is in progress in every state except the three resting ones.
  function automatic logic is_busy_state(input state_e s);
    return !(s inside {ST_IDLE, ST_PASS, ST_FAIL});
  endfunction

endpackage

// File: rtl/sram_test_addr_counter.sv
// rtl/sram_test_addr_counter.sv - SRAM address counter with clear, increment and last-address flag
module sram_test_addr_counter #(
  parameter int ADDR_BITS = 20
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 is_last_o
);

  logic [ADDR_BITS-1:0] addr_q, addr_d;

  // Clear has priority over increment.
  always_comb begin
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = '0;
    end else if (inc_i) begin
      addr_d = addr_q + ADDR_BITS'(1);
    end
  end

  // Address register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o    = addr_q;
  // Last address is all ones; the sequencer never relies on wrap to zero.
  assign is_last_o = &addr_q;

endmodule

// File: rtl/sram_test_controller.sv
// rtl/sram_test_controller.sv - sequences a full SRAM march test over all generator patterns
module sram_test_controller
  import sram_test_controller_pkg::*;
#(
  parameter int ADDR_BITS    = 20,
  parameter int DATA_BITS    = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] gen_pattern,
  input  logic                 gen_done,
  output logic                 gen_next,
  output logic                 gen_reset,
  output logic [ADDR_BITS-1:0] addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 we,
  output logic                 rd_en,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [ADDR_BITS-1:0] fail_addr,
  output logic [DATA_BITS-1:0] fail_expected,
  output logic [DATA_BITS-1:0] fail_actual,
  output logic [PIDX_W-1:0]    pattern_idx
);

  // RWAIT counts down from READ_LATENCY-2 so it lasts READ_LATENCY-1 cycles.
  localparam int              RW_W    = $clog2(READ_LATENCY + 1);
  localparam logic [RW_W-1:0] RW_INIT = RW_W'(READ_LATENCY - 2);

  state_e                 state_q, state_d;
  logic [RW_W-1:0]        rwait_q, rwait_d;
  logic [PIDX_W-1:0]      pattern_idx_q, pattern_idx_d;
  logic                   addr_clr, addr_inc, is_last;
  logic                   clear_results, latch_fail;
  logic                   gen_next_q, gen_reset_q, we_q, rd_en_q;
  logic                   busy_q, pass_q, fail_q;
  logic [DATA_BITS-1:0]   wr_data_q, fail_expected_q, fail_actual_q;
  logic [ADDR_BITS-1:0]   fail_addr_q;

  sram_test_addr_counter #(.ADDR_BITS(ADDR_BITS)) u_addr_counter (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (addr_clr),
    .inc_i     (addr_inc),
    .addr_o    (addr),
    .is_last_o (is_last)
  );

  // Next-state and control decode for the march sequence.
  always_comb begin
    state_d       = state_q;
    rwait_d       = rwait_q;
    pattern_idx_d = pattern_idx_q;
    addr_clr      = 1'b0;
    addr_inc      = 1'b0;
    clear_results = 1'b0;
    latch_fail    = 1'b0;
    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          state_d       = ST_GRST;
          clear_results = 1'b1;
          pattern_idx_d = '0;
        end
      end
      ST_GRST:   state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (gen_done) begin
          state_d = ST_PASS;
        end else begin
          addr_clr = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (is_last) begin
          addr_clr = 1'b1;
          state_d  = ST_READ;
        end else begin
          addr_inc = 1'b1;
        end
      end
      ST_READ: begin
        if (READ_LATENCY == 1) begin
          state_d = ST_CHECK;
        end else begin
          rwait_d = RW_INIT;
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (rwait_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          rwait_d = rwait_q - RW_W'(1);
        end
      end
      ST_CHECK: begin
        if (rd_data != gen_pattern) begin
          latch_fail = 1'b1;
          state_d    = ST_FAIL;
        end else if (is_last) begin
          state_d = ST_NEXT;
        end else begin
          addr_inc = 1'b1;
          state_d  = ST_READ;
        end
      end
      ST_NEXT: begin
        if (pattern_idx_q < PIDX_W'(PATTERN_COUNT - 1)) begin
          pattern_idx_d = pattern_idx_q + PIDX_W'(1);
        end
        state_d = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State plus registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      rwait_q         <= '0;
      pattern_idx_q   <= '0;
      gen_next_q      <= 1'b0;
      gen_reset_q     <= 1'b0;
      we_q            <= 1'b0;
      rd_en_q         <= 1'b0;
      busy_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      wr_data_q       <= '0;
      fail_addr_q     <= '0;
      fail_expected_q <= '0;
      fail_actual_q   <= '0;
    end else begin
      state_q       <= state_d;
      rwait_q       <= rwait_d;
      pattern_idx_q <= pattern_idx_d;
      gen_reset_q   <= (state_d == ST_GRST);
      gen_next_q    <= (state_d == ST_NEXT);
      we_q          <= (state_d == ST_WRITE);
      rd_en_q       <= (state_d == ST_READ);
      busy_q        <= is_busy_state(state_d);
      pass_q        <= (state_d == ST_PASS);
      fail_q        <= (state_d == ST_FAIL);
      if (state_d == ST_WRITE) begin
        wr_data_q <= gen_pattern;
      end
      if (clear_results) begin
        fail_addr_q     <= '0;
        fail_expected_q <= '0;
        fail_actual_q   <= '0;
      end else if (latch_fail) begin
        fail_addr_q     <= addr;
        fail_expected_q <= gen_pattern;
        fail_actual_q   <= rd_data;
      end
    end
  end

  assign gen_next      = gen_next_q;
  assign gen_reset     = gen_reset_q;
  assign we            = we_q;
  assign rd_en         = rd_en_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign fail_addr     = fail_addr_q;
  assign fail_expected = fail_expected_q;
  assign fail_actual   = fail_actual_q;
  assign pattern_idx   = pattern_idx_q;

endmodule

// File: tb/tb_sram_test_controller.sv
// tb/tb_sram_test_controller.sv - scoreboard bench for the SRAM march test controller
module tb_sram_test_controller;

  localparam int AB = 4;
  localparam int DB = 16;
  localparam int N  = 1 << AB;
  localparam logic [15:0] CUSTOM = 16'hA5C3;

  typedef struct {
    bit          is_pass;
    int          faddr;
    logic [15:0] fexp;
    logic [15:0] fact;
    int          pidx;
    int          cycles;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, start_sweep;
  int   fault_mode, fa, fb, sv;
  int   checks = 0, errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] pattern_of(input int k);
    case (k)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h5555;
      3: return 16'hAAAA;
      4: return 16'h3333;
      5: return 16'hCCCC;
      6: return CUSTOM;
      default: return 16'h0000;
    endcase
  endfunction

  // Value a faulty memory returns for a stored word at an address.
  function automatic logic [15:0] apply_fault(input logic [15:0] w, input int a);
    logic [15:0] r;
    r = w;
    if (fault_mode == 1 && a == fa) begin
      if (sv != 0) r = w | (16'h1 << fb);
      else         r = w & ~(16'h1 << fb);
    end else if (fault_mode == 2 && a == 9 && w == CUSTOM) begin
      r = 16'hA5C2;
    end
    return r;
  endfunction

  // Reference: patterns are written everywhere, then read in address order.
  function automatic exp_t model_run(input int lat);
    exp_t e;
    int   per;
    per       = N + N * (lat + 1) + 2;
    e.is_pass = 1'b1;
    e.faddr   = 0;
    e.fexp    = '0;
    e.fact    = '0;
    e.pidx    = 6;
    e.cycles  = 2 + 7 * per;
    for (int k = 0; k < 7; k++) begin
      for (int a = 0; a < N; a++) begin
        logic [15:0] p, r;
        p = pattern_of(k);
        r = apply_fault(p, a);
        if (r != p) begin
          e.is_pass = 1'b0;
          e.faddr   = a;
          e.fexp    = p;
          e.fact    = r;
          e.pidx    = k;
          e.cycles  = 2 + k * per + N + a * (lat + 1) + lat + 1;
          return e;
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int LAT = gi + 1;
    logic          st;
    logic [DB-1:0] gen_pattern, rd_data, wr_data, fail_expected, fail_actual;
    logic          gen_done, gen_next, gen_reset, we, rd_en, busy, pass, fail;
    logic [AB-1:0] addr, fail_addr;
    logic [2:0]    pattern_idx;
    logic [15:0]   mem [N];
    logic [15:0]   pipe [LAT];
    int            gidx;
    int            cyc;

    assign st          = (gi == 1) ? start : start_sweep;
    assign gen_pattern = pattern_of(gidx);
    assign gen_done    = (gidx >= 7);
    assign rd_data     = pipe[LAT-1];

    sram_test_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .READ_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .start(st), .gen_pattern(gen_pattern), .gen_done(gen_done),
      .gen_next(gen_next), .gen_reset(gen_reset), .addr(addr), .wr_data(wr_data), .we(we),
      .rd_en(rd_en), .rd_data(rd_data), .busy(busy), .pass(pass), .fail(fail),
      .fail_addr(fail_addr), .fail_expected(fail_expected), .fail_actual(fail_actual),
      .pattern_idx(pattern_idx)
    );

    always @(posedge clk or posedge reset) begin
      if (reset)                     gidx <= 0;
      else if (gen_reset)            gidx <= 0;
      else if (gen_next && gidx < 7) gidx <= gidx + 1;
    end

    always @(posedge clk) begin
      if (we) mem[addr] <= wr_data;
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= rd_en ? apply_fault(mem[addr], int'(addr)) : 16'hDEAD;
    end

    always @(negedge clk) begin
      if (gen_reset)  cyc <= 0;
      else if (busy)  cyc <= cyc + 1;
    end
  end

  // Monitor: pops the scoreboard when the main controller reports a result.
  bit armed = 1'b0;
  bit excl  = 1'b0;
  int mcyc  = 0;
  always @(negedge clk) begin
    if (reset) begin
      armed = 1'b0;
    end else if (g[1].gen_reset) begin
      armed = 1'b1;
      mcyc  = 0;
      excl  = 1'b0;
    end else if (armed) begin
      mcyc++;
      if (g[1].we && g[1].rd_en) excl = 1'b1;
      if (g[1].pass || g[1].fail) begin
        armed = 1'b0;
        check("sb_entry_missing", exp_q.size() == 0, 0);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("pass", g[1].pass, e.is_pass);
          check("fail", g[1].fail, !e.is_pass);
          check("pattern_idx", g[1].pattern_idx, e.pidx);
          check("cycles_to_result", mcyc, e.cycles);
          check("we_rd_exclusive", excl, 0);
          if (!e.is_pass) begin
            check("fail_addr", g[1].fail_addr, e.faddr);
            check("fail_expected", g[1].fail_expected, e.fexp);
            check("fail_actual", g[1].fail_actual, e.fact);
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_strobes"}, {g[1].we, g[1].rd_en, g[1].gen_next, g[1].gen_reset}, 0);
    check({tag, "_status"}, {g[1].busy, g[1].pass, g[1].fail}, 0);
    check({tag, "_addr"}, g[1].addr, 0);
    check({tag, "_wr_data"}, g[1].wr_data, 0);
    check({tag, "_fail_diag"}, {g[1].fail_addr, g[1].fail_expected, g[1].fail_actual}, 0);
    check({tag, "_pattern_idx"}, g[1].pattern_idx, 0);
  endtask

  task automatic start_run(input bit push, input bit hold, input bit sweep);
    @(negedge clk);
    check("pre_start_idle", g[1].busy, 0);
    if (push) exp_q.push_back(model_run(2));
    start = 1'b1;
    if (sweep) start_sweep = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    start_sweep = 1'b0;
    check("busy_rise", g[1].busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (g[1].busy && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("run_timeout", g[1].busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_sweep = 1'b0;
    fault_mode = 0; fa = 0; fb = 0; sv = 0;
    #3 check_zero("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Clean memory on all three latencies.
    start_run(1, 0, 1);
    wait_idle();
    begin
      int n = 0;
      while ((g[0].busy || g[2].busy) && n < 1000) begin
        @(negedge clk);
        n++;
      end
    end
    check("sweep_timeout", {g[0].busy, g[2].busy}, 0);
    check("lat1_pass", {g[0].pass, g[0].fail}, 2'b10);
    check("lat1_cycles", g[0].cyc + 1, model_run(1).cycles);
    check("lat3_pass", {g[2].pass, g[2].fail}, 2'b10);
    check("lat3_cycles", g[2].cyc + 1, model_run(3).cycles);

    // Bit 3 stuck at 1 at address 5.
    fault_mode = 1; fa = 5; fb = 3; sv = 1;
    start_run(1, 0, 0);
    wait_idle();

    // Restart from FAIL on a healthy memory.
    fault_mode = 0;
    start_run(1, 0, 0);
    check("restart_clears_fail", g[1].fail, 0);
    check("restart_clears_fail_addr", g[1].fail_addr, 0);
    wait_idle();

    // Address 9 corrupts only the custom pattern.
    fault_mode = 2;
    start_run(1, 0, 0);
    wait_idle();

    // Random stuck-at faults.
    for (int r = 0; r < 4; r++) begin
      fault_mode = 1;
      fa = $urandom_range(0, N - 1);
      fb = $urandom_range(0, 15);
      sv = $urandom_range(0, 1);
      repeat ($urandom_range(1, 5)) @(negedge clk);
      start_run(1, 0, 0);
      wait_idle();
    end

    // Reset during a READ of pattern 2, then a clean rerun.
    fault_mode = 0;
    start_run(0, 0, 0);
    begin
      int n = 0;
      while (!(g[1].pattern_idx == 2 && g[1].rd_en) && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end
    check("reach_pattern2_read", {g[1].pattern_idx, g[1].rd_en}, {3'd2, 1'b1});
    #2 reset = 1'b1;
    #1 check_zero("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    start_run(1, 0, 0);
    wait_idle();

    // Start held high throughout a run.
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start_run(1, 1, 0);
    wait_idle();
    start = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_test_controller.md
# sram_test_controller

Sequences a full SRAM march test: it drives the pattern generator, writes each pattern to every address, reads every address back and compares. It sits between the pattern generator and the SRAM controller port in the SRAM test example, and reports pass or fail with first-failure diagnostics to the top level (LEDs/UART).

## Interface

Parameters:
- ADDR_BITS, 20: SRAM address width; the test covers 2^ADDR_BITS words.
- DATA_BITS, 16: SRAM and pattern word width.
- READ_LATENCY, 2: cycles from the rd_en cycle to the cycle rd_data is valid; must be ≥ 1.

Ports:
- clk  in  1: system clock.
- reset  in  1: reset, asynchronous, active-high.
- start  in  1: begin a test run; sampled only in IDLE, PASS or FAIL.
- gen_pattern  in  DATA_BITS: current pattern from the generator.
- gen_done  in  1: generator has stepped past its final pattern.
- gen_next  out  1: one-cycle registered pulse that advances the generator.
- gen_reset  out  1: one-cycle registered pulse that resets the generator.
- addr  out  ADDR_BITS: SRAM address.
- wr_data  out  DATA_BITS: SRAM write data.
- we  out  1: SRAM write strobe, one word per cycle.
- rd_en  out  1: SRAM read strobe.
- rd_data  in  DATA_BITS: SRAM read data.
- busy  out  1: a test run is in progress.
- pass  out  1: sticky; all patterns verified.
- fail  out  1: sticky; a mismatch was detected.
- fail_addr  out  ADDR_BITS: address of the first mismatch.
- fail_expected  out  DATA_BITS: expected word at the first mismatch.
- fail_actual  out  DATA_BITS: read word at the first mismatch.
- pattern_idx  out  3: index of the pattern under test (0..6).

## Operation

- States: IDLE, GRST, SETTLE, WRITE, READ, RWAIT, CHECK, NEXT, PASS, FAIL.
- IDLE/PASS/FAIL + start goes to GRST. On this transition the controller clears pass, fail, the diagnostics and pattern_idx.
- GRST: gen_reset=1, then SETTLE.
- SETTLE: one cycle that lets the generator output settle.
  - If gen_done=1, go to PASS.
  - Otherwise clear addr to 0 and go to WRITE.
- WRITE: we=1, addr=current address, wr_data=gen_pattern.
  - If addr is the maximum, clear addr and go to READ.
  - Otherwise increment addr.
- READ: rd_en=1 for one cycle.
  - Go to RWAIT for READ_LATENCY-1 cycles, then CHECK.
  - If READ_LATENCY=1, go straight to CHECK.
- CHECK: compare rd_data with gen_pattern.
  - Mismatch: latch addr, gen_pattern and rd_data into the fail_* outputs, then go to FAIL.
  - Match at the last address: go to NEXT.
  - Match otherwise: increment addr and go to READ.
- NEXT: gen_next=1, increment pattern_idx (saturating at 6), then SETTLE.
- PASS: pass=1. FAIL: fail=1. Both hold until start or reset.
- start while busy is ignored.
- The address counter is ADDR_BITS wide. The last address is detected by an all-ones compare, never by a wrap to 0.

## Timing

- Reset values:
  - State is IDLE.
  - All outputs are 0, including addr, wr_data, fail_* and pattern_idx.
  - we, rd_en, gen_next and gen_reset are deasserted immediately, asynchronously.
- All outputs are registered.
- busy=1 in every state except IDLE, PASS and FAIL.
- Per address, the write phase takes 1 cycle and the read phase takes READ_LATENCY+1 cycles.
- With N=2^ADDR_BITS, one pattern takes N + N·(READ_LATENCY+1) + 2 cycles (NEXT and SETTLE).
- The generator yields 7 patterns. gen_done is observed in the SETTLE after the 7th NEXT.
- reset mid-run aborts at once. No partial results are retained.
- The controller relies on the SRAM never needing we and rd_en in the same cycle. The FSM guarantees this.

## Structure

- A shared package holds the state encoding, the pattern count (7) and the pattern_idx width.
- One natural sub-module: sram_test_addr_counter, holding the address counter, its clear and increment controls, and the is_last flag.
- The compare and the diagnostic latch stay inline.

## Test plan

All scenarios use ADDR_BITS=4, DATA_BITS=16, READ_LATENCY=2, the real pattern generator with custom=16'hA5C3, and a behavioural SRAM.

- Clean memory, start pulse:
  - busy rises 1 cycle later.
  - pass=1 exactly 464 cycles after GRST: 2 cycles of GRST/SETTLE, plus 7·66, then PASS.
  - fail stays 0 and pattern_idx ends at 6.
- Bit 3 stuck-at-1 at address 5:
  - fail=1, fail_addr=5, fail_expected=16'h0000, fail_actual=16'h0008, pattern_idx=0.
- Address 9 returns 16'hA5C2 only for the custom pattern:
  - fail with fail_addr=9, fail_expected=16'hA5C3, pattern_idx=6.
- Sweep READ_LATENCY=1 and 3 on clean memory:
  - pass, with per-pattern cycles 50 and 82 respectively.
- Assert reset during the READ of pattern 2:
  - All outputs return to 0 asynchronously.
  - A subsequent start runs cleanly to pass.
- Edge cases around start:
  - start held high through a whole run has no effect while busy.
  - start in FAIL clears fail and fail_addr, then re-runs the test.
